// File: rtl/lock_controller_pkg.sv
// Shared key-code constants, FSM state encoding and a key classification
// helper for the keypad lock controller.
package lock_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Encoding 2'd3 is unused; the controller steers it back to ST_LOCKED.
    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Codes 0-9 are digits; 'hA/'hB are command keys; 'hC-'hF are invalid.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad-side bundle of the lock controller: scanner code/valid in,
// lock status and debug outputs back.
interface lock_controller_if;

    logic [3:0] Code;
    logic       Valid;
    logic       Unlock;
    logic       Alarm;
    logic       Err;
    logic [2:0] Count;
    logic [1:0] State;

    // Keypad scanner / test driver side.
    modport master (
        output Code,
        output Valid,
        input  Unlock,
        input  Alarm,
        input  Err,
        input  Count,
        input  State
    );

    // Lock controller side.
    modport slave (
        input  Code,
        input  Valid,
        output Unlock,
        output Alarm,
        output Err,
        output Count,
        output State
    );

endinterface

// File: rtl/lock_controller_key_edge.sv
// Key press detector: turns a held Valid level into a single-cycle strobe
// in the cycle Valid is first seen high, and presents the key code with it.
module key_edge (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [3:0] code,
    output logic       key_stb,
    output logic [3:0] key_code
);

    logic valid_d;
    logic valid_q;

    // Next value of the edge register is simply the current Valid level.
    always_comb begin
        valid_d = valid;
    end

    // Edge register holding Valid from the previous cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Code is stable while Valid is high, so it can travel with the strobe
    // directly; the controller registers the effect of the key.
    assign key_stb  = valid & ~valid_q;
    assign key_code = code;

endmodule

// File: rtl/lock_controller.sv
// Keypad lock controller: password entry, open window with password change,
// and lockout after repeated failures. All outputs are registered.
module lock_controller
    import lock_pkg::*;
#(
    parameter int                  PW_LEN         = 4,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW     = 16'h1234,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  OPEN_CYCLES    = 1000,
    parameter int                  LOCKOUT_CYCLES = 5000
) (
    input  logic              clock,
    input  logic              reset,
    lock_controller_if.slave  kp
);

    localparam int BW   = PW_LEN * 4;
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);

    localparam logic [2:0]    FULL   = 3'(PW_LEN);
    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [FW-1:0] F_MAX  = FW'(MAX_TRIES);

    logic          key_stb;
    logic [3:0]    key_code;

    state_t        state_q;
    logic [BW-1:0] buf_q;
    logic [2:0]    count_q;
    logic          over_q;
    logic [FW-1:0] fail_q;
    logic [TW-1:0] timer_q;
    logic [BW-1:0] pw_q;
    logic          unlock_q;
    logic          alarm_q;
    logic          err_q;

    logic [BW-1:0] buf_shift;
    logic [FW-1:0] fail_inc;
    logic          entry_full;
    logic          expire;

    key_edge u_key_edge (
        .clock    (clock),
        .reset    (reset),
        .valid    (kp.Valid),
        .code     (kp.Code),
        .key_stb  (key_stb),
        .key_code (key_code)
    );

    assign buf_shift  = (buf_q << 4) | BW'(key_code);
    assign fail_inc   = fail_q + FW'(1);
    assign entry_full = (count_q == FULL) && !over_q;
    // Timer reaching its last cycle ends OPEN/LOCKOUT and shadows any key.
    assign expire     = (timer_q <= T_ONE);

    // Main FSM: state, entry buffer, counters, stored password and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOCKED;
            buf_q    <= '0;
            count_q  <= '0;
            over_q   <= 1'b0;
            fail_q   <= '0;
            timer_q  <= '0;
            pw_q     <= DEFAULT_PW;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_LOCKED: begin
                    if (key_stb) begin
                        if (is_digit(key_code)) begin
                            if (count_q == FULL) begin
                                over_q <= 1'b1;
                            end else begin
                                buf_q   <= buf_shift;
                                count_q <= count_q + 3'd1;
                            end
                        end else if (key_code == KEY_STAR) begin
                            buf_q   <= '0;
                            count_q <= '0;
                            over_q  <= 1'b0;
                        end else if (key_code == KEY_HASH && count_q != 3'd0) begin
                            buf_q   <= '0;
                            count_q <= '0;
                            over_q  <= 1'b0;
                            if (entry_full && buf_q == pw_q) begin
                                state_q  <= ST_OPEN;
                                unlock_q <= 1'b1;
                                fail_q   <= '0;
                                timer_q  <= T_OPEN;
                            end else begin
                                err_q  <= 1'b1;
                                fail_q <= fail_inc;
                                if (fail_inc == F_MAX) begin
                                    state_q <= ST_LOCKOUT;
                                    alarm_q <= 1'b1;
                                    timer_q <= T_LOCK;
                                end
                            end
                        end
                    end
                end

                ST_OPEN: begin
                    if (expire) begin
                        state_q  <= ST_LOCKED;
                        unlock_q <= 1'b0;
                        timer_q  <= '0;
                        buf_q    <= '0;
                        count_q  <= '0;
                        over_q   <= 1'b0;
                    end else begin
                        timer_q <= timer_q - T_ONE;
                        if (key_stb) begin
                            if (is_digit(key_code)) begin
                                if (count_q == FULL) begin
                                    over_q <= 1'b1;
                                end else begin
                                    buf_q   <= buf_shift;
                                    count_q <= count_q + 3'd1;
                                end
                            end else if (key_code == KEY_STAR) begin
                                state_q  <= ST_LOCKED;
                                unlock_q <= 1'b0;
                                timer_q  <= '0;
                                buf_q    <= '0;
                                count_q  <= '0;
                                over_q   <= 1'b0;
                            end else if (key_code == KEY_HASH) begin
                                buf_q   <= '0;
                                count_q <= '0;
                                over_q  <= 1'b0;
                                if (entry_full) begin
                                    pw_q     <= buf_q;
                                    state_q  <= ST_LOCKED;
                                    unlock_q <= 1'b0;
                                    timer_q  <= '0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (expire) begin
                        state_q <= ST_LOCKED;
                        alarm_q <= 1'b0;
                        fail_q  <= '0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - T_ONE;
                    end
                end

                default: begin
                    state_q  <= ST_LOCKED;
                    unlock_q <= 1'b0;
                    alarm_q  <= 1'b0;
                    timer_q  <= '0;
                    buf_q    <= '0;
                    count_q  <= '0;
                    over_q   <= 1'b0;
                end
            endcase
        end
    end

    assign kp.Unlock = unlock_q;
    assign kp.Alarm  = alarm_q;
    assign kp.Err    = err_q;
    assign kp.Count  = count_q;
    assign kp.State  = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: every key press queues the expected
// {State, Count, Unlock, Alarm, Err} for the cycle after acceptance; a
// monitor pops and compares when it sees the press accepted.
module tb_lock_controller;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lock_controller_if kp ();

    lock_controller #(
        .OPEN_CYCLES    (20),
        .LOCKOUT_CYCLES (50)
    ) dut (
        .clock (clk),
        .reset (rst),
        .kp    (kp)
    );

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    int unlock_run  = 0;
    int alarm_run   = 0;
    int unlock_last = 0;
    int alarm_last  = 0;
    logic vprev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] e(input logic [1:0] st, input int cnt,
                                     input logic un, input logic al, input logic er);
        return {st, 3'(cnt), un, al, er};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {kp.State, kp.Count, kp.Unlock, kp.Alarm, kp.Err};
    endfunction

    // Bench-side copy of the previous Valid level, used to spot acceptance.
    always @(posedge clk) begin
        if (rst) vprev <= 1'b0;
        else     vprev <= kp.Valid;
    end

    // Monitor: one scoreboard entry per accepted press, checked 1ns later.
    always @(posedge clk) begin
        if (!rst && kp.Valid && !vprev) begin
            sb_item_t it;
            #1;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd0, 32'd1);
            end else begin
                it = sb.pop_front();
                check_eq(it.tag, {24'd0, obs_vec()}, {24'd0, it.exp});
            end
        end
    end

    // High-time run lengths of Unlock and Alarm, sampled on the falling edge.
    always @(negedge clk) begin
        if (kp.Unlock) unlock_run <= unlock_run + 1;
        else if (unlock_run != 0) begin
            unlock_last <= unlock_run;
            unlock_run  <= 0;
        end
        if (kp.Alarm) alarm_run <= alarm_run + 1;
        else if (alarm_run != 0) begin
            alarm_last <= alarm_run;
            alarm_run  <= 0;
        end
    end

    task automatic press(input logic [3:0] c, input int hold, input string tag, input logic [7:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
        @(negedge clk);
        kp.Code  = c;
        kp.Valid = 1'b1;
        repeat (hold) @(negedge clk);
        kp.Valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_pw(input logic [15:0] pw, input int hold, input logic [1:0] st, input logic un);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = pw[15-4*i -: 4];
            press(d, hold, "digit", e(st, i + 1, un, 1'b0, 1'b0));
        end
    endtask

    task automatic wait_low(input bit alarm_sel);
        int n;
        n = 0;
        while ((alarm_sel ? kp.Alarm : kp.Unlock) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq(alarm_sel ? "alarm_timeout" : "unlock_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        kp.Code  = 4'd0;
        kp.Valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_vec", {24'd0, obs_vec()}, {24'd0, e(ST_LOCKED, 0, 0, 0, 0)});
        rst = 1'b0;

        // Correct code opens for 20 cycles; partial new password lost on expiry.
        press_pw(16'h1234, 5, ST_LOCKED, 1'b0);
        press(KEY_HASH, 5, "open_hash", e(ST_OPEN, 0, 1, 0, 0));
        press(4'd5, 1, "open_d1", e(ST_OPEN, 1, 1, 0, 0));
        press(4'd6, 1, "open_d2", e(ST_OPEN, 2, 1, 0, 0));
        wait_low(1'b0);
        check_eq("open_len", unlock_last, 20);
        check_eq("expire_vec", {24'd0, obs_vec()}, {24'd0, e(ST_LOCKED, 0, 0, 0, 0)});

        // Star clears entry; wrong count in OPEN errs; star relocks; lone hash ignored.
        press(4'd1, 1, "pre1", e(ST_LOCKED, 1, 0, 0, 0));
        press(4'd2, 1, "pre2", e(ST_LOCKED, 2, 0, 0, 0));
        press(KEY_STAR, 1, "star_clr", e(ST_LOCKED, 0, 0, 0, 0));
        press_pw(16'h1234, 1, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "open2", e(ST_OPEN, 0, 1, 0, 0));
        press(4'd5, 1, "open2_d", e(ST_OPEN, 1, 1, 0, 0));
        press(KEY_HASH, 1, "open_short", e(ST_OPEN, 0, 1, 0, 1));
        press(KEY_STAR, 1, "open_star", e(ST_LOCKED, 0, 0, 0, 0));
        press(KEY_HASH, 1, "lone_hash", e(ST_LOCKED, 0, 0, 0, 0));
        press(4'd7, 1, "d7", e(ST_LOCKED, 1, 0, 0, 0));
        press(4'hC, 1, "invalid_c", e(ST_LOCKED, 1, 0, 0, 0));
        press(KEY_STAR, 1, "star2", e(ST_LOCKED, 0, 0, 0, 0));

        // Three wrong codes -> lockout for 50 cycles, keys ignored meanwhile.
        for (int t = 0; t < 3; t++) begin
            press_pw(16'h1235, 1, ST_LOCKED, 1'b0);
            press(KEY_HASH, 1, "bad_hash",
                  (t == 2) ? e(ST_LOCKOUT, 0, 0, 1, 1) : e(ST_LOCKED, 0, 0, 0, 1));
        end
        press(4'd1, 1, "lo_key", e(ST_LOCKOUT, 0, 0, 1, 0));
        press(4'd2, 1, "lo_key", e(ST_LOCKOUT, 0, 0, 1, 0));
        press(4'd3, 1, "lo_key", e(ST_LOCKOUT, 0, 0, 1, 0));
        press(4'd4, 1, "lo_key", e(ST_LOCKOUT, 0, 0, 1, 0));
        press(KEY_HASH, 1, "lo_hash", e(ST_LOCKOUT, 0, 0, 1, 0));
        wait_low(1'b1);
        check_eq("lockout_len", alarm_last, 50);
        check_eq("lockout_end", {24'd0, obs_vec()}, {24'd0, e(ST_LOCKED, 0, 0, 0, 0)});

        // Fail counter restarted: two more failures stay LOCKED.
        for (int t = 0; t < 2; t++) begin
            press_pw(16'h1235, 1, ST_LOCKED, 1'b0);
            press(KEY_HASH, 1, "post_lo_bad", e(ST_LOCKED, 0, 0, 0, 1));
        end
        press_pw(16'h1234, 1, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "open3", e(ST_OPEN, 0, 1, 0, 0));
        press(KEY_STAR, 1, "open3_star", e(ST_LOCKED, 0, 0, 0, 0));

        // Overlong entry: count saturates, hash errs.
        press_pw(16'h1234, 1, ST_LOCKED, 1'b0);
        press(4'd5, 1, "overlong_d", e(ST_LOCKED, 4, 0, 0, 0));
        press(KEY_HASH, 1, "overlong_hash", e(ST_LOCKED, 0, 0, 0, 1));

        // Reset mid-OPEN with two new digits: immediate abort, password kept.
        press_pw(16'h1234, 5, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "open4", e(ST_OPEN, 0, 1, 0, 0));
        press(4'd5, 1, "open4_d1", e(ST_OPEN, 1, 1, 0, 0));
        press(4'd6, 1, "open4_d2", e(ST_OPEN, 2, 1, 0, 0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_unlock", {31'd0, kp.Unlock}, 32'd0);
        check_eq("rst_count", {29'd0, kp.Count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        press_pw(16'h1234, 1, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "pw_kept", e(ST_OPEN, 0, 1, 0, 0));
        press(KEY_STAR, 1, "pw_kept_star", e(ST_LOCKED, 0, 0, 0, 0));

        // Password change to 9876, old code then fails, new code opens.
        press_pw(16'h1234, 5, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "open5", e(ST_OPEN, 0, 1, 0, 0));
        press_pw(16'h9876, 1, ST_OPEN, 1'b1);
        press(KEY_HASH, 1, "store_pw", e(ST_LOCKED, 0, 0, 0, 0));
        press_pw(16'h1234, 1, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "old_pw", e(ST_LOCKED, 0, 0, 0, 1));
        press_pw(16'h9876, 1, ST_LOCKED, 1'b0);
        press(KEY_HASH, 1, "new_pw", e(ST_OPEN, 0, 1, 0, 0));
        wait_low(1'b0);
        check_eq("open_len2", unlock_last, 20);

        repeat (2) @(negedge clk);
        check_eq("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
